// File: rtl/spi_slave_dp_if.sv
// SPI slave pins plus the parallel RAM-side word/strobe bundle; DATA_W sets payload width.
// No buffering here: wiring only, the slave modport is the RTL side.
interface spi_slave_dp_if #(
  parameter int DATA_W = 8
) ();
  localparam int W = DATA_W + 2;

  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [W-1:0]      rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              cmd_err;
  logic              busy;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, cmd_err, busy
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, cmd_err, busy
  );
endinterface

// File: rtl/spi_slave_dp.sv
// SPI slave front-end: word accepted W edges after frame start, read data streamed MSB-first on MISO.
// No backpressure: WAIT_TX stalls until tx_valid; SS_n high aborts any frame on the next edge.
module spi_slave_dp #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_slave_dp_if.slave spi
);
  localparam int W  = DATA_W + 2;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, HOLD
  } state_t;

  state_t            state_q;
  logic [W-2:0]      rx_sh_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [CW-1:0]     cnt_q;
  logic              rd_addr_pend_q;
  logic              miso_q;
  logic              rx_valid_q;
  logic              cmd_err_q;
  logic [W-1:0]      rx_data_q;

  logic [W-1:0]      word_d;
  logic              last_rx_d;
  logic              last_tx_d;
  logic              accept_d;

  assign word_d    = {rx_sh_q, spi.MOSI};
  assign last_rx_d = (cnt_q == CW'(W - 1));
  assign last_tx_d = (cnt_q == CW'(DATA_W));
  // A write frame can only carry codes 00/01, so WRITE always accepts.
  assign accept_d  = (state_q == WRITE) ||
                     (state_q == READ_ADD  && word_d[W-1:W-2] == 2'b10) ||
                     (state_q == READ_DATA && word_d[W-1:W-2] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rx_sh_q        <= '0;
      tx_sh_q        <= '0;
      cnt_q          <= '0;
      rd_addr_pend_q <= 1'b1;
      miso_q         <= 1'b0;
      rx_valid_q     <= 1'b0;
      cmd_err_q      <= 1'b0;
      rx_data_q      <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      if (spi.SS_n) begin
        state_q <= IDLE;
        miso_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            state_q <= CHK_CMD;
          end
          CHK_CMD: begin
            rx_sh_q <= {rx_sh_q[W-3:0], spi.MOSI};
            cnt_q   <= CW'(1);
            if (!spi.MOSI)          state_q <= WRITE;
            else if (rd_addr_pend_q) state_q <= READ_ADD;
            else                    state_q <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            rx_sh_q <= {rx_sh_q[W-3:0], spi.MOSI};
            cnt_q   <= cnt_q + CW'(1);
            if (last_rx_d) begin
              if (accept_d) begin
                rx_data_q  <= word_d;
                rx_valid_q <= 1'b1;
                if (state_q == READ_ADD) rd_addr_pend_q <= 1'b0;
                state_q <= (state_q == READ_DATA) ? WAIT_TX : HOLD;
              end else begin
                cmd_err_q <= 1'b1;
                state_q   <= HOLD;
              end
            end
          end
          WAIT_TX: begin
            if (spi.tx_valid) begin
              tx_sh_q <= spi.tx_data;
              miso_q  <= spi.tx_data[DATA_W-1];
              cnt_q   <= CW'(1);
              state_q <= SEND;
            end
          end
          SEND: begin
            // cnt_q counts bits already on MISO; the LSB holds one full cycle before release.
            if (last_tx_d) begin
              miso_q         <= 1'b0;
              rd_addr_pend_q <= 1'b1;
              state_q        <= HOLD;
            end else begin
              miso_q  <= tx_sh_q[DATA_W-2];
              tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
              cnt_q   <= cnt_q + CW'(1);
            end
          end
          HOLD: state_q <= HOLD;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi.MISO     = miso_q;
  assign spi.rx_data  = rx_data_q;
  assign spi.rx_valid = rx_valid_q;
  assign spi.cmd_err  = cmd_err_q;
  assign spi.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave_dp.sv
// Bench for spi_slave_dp at DATA_W=8 and DATA_W=16: directed table, hand-built abort/reset cases,
// then random frames checked against a frame-level model of the command/read-pairing rules.
module tb_spi_slave_dp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_n;
  logic        mosi;
  logic        tx_vld;
  logic [15:0] tx_dat;
  int          cur;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          fidx  = 0;

  always #5 clk = ~clk;

  spi_slave_dp_if #(.DATA_W(8))  if8 ();
  spi_slave_dp_if #(.DATA_W(16)) if16 ();

  // Only the selected DUT sees SS_n low; the other sits in IDLE.
  assign if8.SS_n      = (cur != 0) ? 1'b1 : ss_n;
  assign if16.SS_n     = (cur != 0) ? ss_n : 1'b1;
  assign if8.MOSI      = mosi;
  assign if16.MOSI     = mosi;
  assign if8.tx_valid  = tx_vld;
  assign if16.tx_valid = tx_vld;
  assign if8.tx_data   = tx_dat[7:0];
  assign if16.tx_data  = tx_dat;

  spi_slave_dp #(.DATA_W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .spi(if8));
  spi_slave_dp #(.DATA_W(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .spi(if16));

  logic        miso_m, vld_m, err_m, busy_m;
  logic [17:0] rx_m;
  assign miso_m = (cur != 0) ? if16.MISO     : if8.MISO;
  assign vld_m  = (cur != 0) ? if16.rx_valid : if8.rx_valid;
  assign err_m  = (cur != 0) ? if16.cmd_err  : if8.cmd_err;
  assign busy_m = (cur != 0) ? if16.busy     : if8.busy;
  assign rx_m   = (cur != 0) ? if16.rx_data  : {8'b0, if8.rx_data};

  // Frame-level model state: which read command is expected next, last accepted word.
  logic        pend_m [2];
  logic [17:0] rxm    [2];

  typedef struct {
    int          sel;
    logic [17:0] w;
    int          nb;
    int          dly;
    logic [15:0] txd;
    int          sab;
    bit          rst;
    logic        ev;
    logic        ee;
    logic [17:0] erx;
  } vec_t;
  vec_t tbl [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s frame %0d dut%0d: got %0h, expected %0h", nm, fidx, (cur != 0) ? 16 : 8, act, exp);
    end
  endtask

  function automatic void predict(input int s, input logic [17:0] w, input int nb, input int sab,
                                  output logic ev, output logic ee, output logic [17:0] erx);
    int dw = (s != 0) ? 16 : 8;
    logic [1:0] code = w[dw+1 -: 2];
    ev = 1'b0;
    ee = 1'b0;
    if (nb >= dw + 2) begin
      if (!code[1]) ev = 1'b1;
      else if (pend_m[s]) begin
        if (code == 2'b10) begin ev = 1'b1; pend_m[s] = 1'b0; end
        else ee = 1'b1;
      end else begin
        if (code == 2'b11) begin ev = 1'b1; if (sab < 0) pend_m[s] = 1'b1; end
        else ee = 1'b1;
      end
    end
    if (ev) rxm[s] = w;
    erx = rxm[s];
  endfunction

  task automatic run_frame(input logic [17:0] w, input int nb, input int dly, input logic [15:0] txd,
                           input int sab, input bit use_rst, input logic ev, input logic ee,
                           input logic [17:0] erx);
    int dw = (cur != 0) ? 16 : 8;
    int ww = dw + 2;
    ss_n = 1'b0;
    tick();
    chk("busy_edge0", 18'(busy_m), 18'd1);
    for (int i = 0; i < nb && i < ww; i++) begin
      mosi = w[ww-1-i];
      tick();
      chk("miso_during_rx", 18'(miso_m), 18'd0);
    end
    if (nb < ww) begin
      ss_n = 1'b1;
      tick();
      chk("abort_rx_valid", 18'(vld_m), 18'd0);
      chk("abort_cmd_err", 18'(err_m), 18'd0);
      chk("abort_busy", 18'(busy_m), 18'd0);
      chk("abort_rx_data", rx_m, erx);
      return;
    end
    chk("rx_valid", 18'(vld_m), 18'(ev));
    chk("cmd_err", 18'(err_m), 18'(ee));
    chk("rx_data", rx_m, erx);
    if (ev && w[ww-1 -: 2] == 2'b11) begin
      if (dly == 0) begin tx_vld = 1'b1; tx_dat = txd; end
      for (int d = 0; d < dly; d++) begin
        tick();
        chk("wait_rx_valid_drop", 18'(vld_m), 18'd0);
        chk("wait_miso", 18'(miso_m), 18'd0);
        if (d == dly - 1) begin tx_vld = 1'b1; tx_dat = txd; end
      end
      tick();
      tx_vld = 1'b0;
      tx_dat = 16'($urandom);
      for (int k = 0; k <= dw; k++) begin
        if (k == sab) begin
          if (use_rst) begin
            rst_n = 1'b0;
            #1;
            chk("rst_miso", 18'(miso_m), 18'd0);
            chk("rst_busy", 18'(busy_m), 18'd0);
            chk("rst_rx_valid", 18'(vld_m), 18'd0);
            chk("rst_cmd_err", 18'(err_m), 18'd0);
            chk("rst_rx_data", rx_m, 18'd0);
            #1;
            rst_n = 1'b1;
          end
          ss_n = 1'b1;
          tick();
          chk("send_abort_miso", 18'(miso_m), 18'd0);
          chk("send_abort_busy", 18'(busy_m), 18'd0);
          return;
        end
        if (k < dw) chk("miso_bit", 18'(miso_m), 18'(txd[dw-1-k]));
        else begin
          chk("miso_after_lsb", 18'(miso_m), 18'd0);
          chk("busy_hold", 18'(busy_m), 18'd1);
        end
        if (k < dw) tick();
      end
    end else begin
      tick();
      chk("rx_valid_one_cycle", 18'(vld_m), 18'd0);
      chk("cmd_err_one_cycle", 18'(err_m), 18'd0);
      chk("busy_hold", 18'(busy_m), 18'd1);
    end
    ss_n = 1'b1;
    tick();
    chk("busy_idle", 18'(busy_m), 18'd0);
    chk("miso_idle", 18'(miso_m), 18'd0);
  endtask

  initial begin
    logic ev, ee;
    logic [17:0] erx;
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_vld = 1'b0; tx_dat = '0; cur = 0;
    pend_m[0] = 1'b1; pend_m[1] = 1'b1; rxm[0] = '0; rxm[1] = '0;

    //            sel  word      nb  dly txd       sab rst ev ee erx
    tbl.push_back('{0, 18'h000A5, 10, 0, 16'h0000, -1, 0, 1, 0, 18'h000A5});
    tbl.push_back('{0, 18'h00300, 10, 0, 16'h0000, -1, 0, 0, 1, 18'h000A5});
    tbl.push_back('{0, 18'h00233, 10, 0, 16'h0000, -1, 0, 1, 0, 18'h00233});
    tbl.push_back('{0, 18'h00300, 10, 3, 16'h00C6, -1, 0, 1, 0, 18'h00300});
    tbl.push_back('{0, 18'h0025A, 10, 0, 16'h0000, -1, 0, 1, 0, 18'h0025A});
    tbl.push_back('{0, 18'h00011, 10, 0, 16'h0000, -1, 0, 1, 0, 18'h00011});
    tbl.push_back('{0, 18'h00277, 10, 0, 16'h0000, -1, 0, 0, 1, 18'h00011});
    tbl.push_back('{0, 18'h00300, 10, 0, 16'h0081,  3, 0, 1, 0, 18'h00300});
    tbl.push_back('{0, 18'h003A5, 10, 1, 16'h005A, -1, 0, 1, 0, 18'h003A5});
    tbl.push_back('{0, 18'h000A5,  5, 0, 16'h0000, -1, 0, 0, 0, 18'h003A5});
    tbl.push_back('{0, 18'h001F0, 10, 0, 16'h0000, -1, 0, 1, 0, 18'h001F0});
    tbl.push_back('{0, 18'h00233, 10, 0, 16'h0000, -1, 0, 1, 0, 18'h00233});
    tbl.push_back('{0, 18'h00300, 10, 2, 16'h00FF,  4, 1, 1, 0, 18'h00300});
    tbl.push_back('{0, 18'h00300, 10, 0, 16'h0000, -1, 0, 0, 1, 18'h00000});
    tbl.push_back('{1, 18'h1BEEF, 18, 0, 16'h0000, -1, 0, 1, 0, 18'h1BEEF});
    tbl.push_back('{1, 18'h21234, 18, 0, 16'h0000, -1, 0, 1, 0, 18'h21234});
    tbl.push_back('{1, 18'h30000, 18, 1, 16'hA53C, -1, 0, 1, 0, 18'h30000});
    tbl.push_back('{1, 18'h20001, 18, 0, 16'h0000, -1, 0, 1, 0, 18'h20001});

    #12;
    for (int s = 0; s < 2; s++) begin
      cur = s;
      #0;
      chk("reset_miso", 18'(miso_m), 18'd0);
      chk("reset_rx_valid", 18'(vld_m), 18'd0);
      chk("reset_rx_data", rx_m, 18'd0);
      chk("reset_cmd_err", 18'(err_m), 18'd0);
      chk("reset_busy", 18'(busy_m), 18'd0);
    end
    cur = 0;
    #1 rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      fidx = i;
      cur  = tbl[i].sel;
      predict(tbl[i].sel, tbl[i].w, tbl[i].nb, tbl[i].sab, ev, ee, erx);
      run_frame(tbl[i].w, tbl[i].nb, tbl[i].dly, tbl[i].txd, tbl[i].sab, tbl[i].rst,
                tbl[i].ev, tbl[i].ee, tbl[i].erx);
      if (tbl[i].rst) begin
        pend_m[0] = 1'b1; pend_m[1] = 1'b1; rxm[0] = '0; rxm[1] = '0;
      end
    end

    for (int r = 0; r < 80; r++) begin
      int dw, ww, nb, dly, sab;
      logic [17:0] w;
      logic [15:0] txd;
      fidx = 100 + r;
      cur  = int'($urandom_range(0, 1));
      dw   = (cur != 0) ? 16 : 8;
      ww   = dw + 2;
      w    = (18'($urandom_range(0, 3)) << dw) | (18'($urandom) & ((18'd1 << dw) - 18'd1));
      nb   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ww - 1)) : ww;
      dly  = int'($urandom_range(0, 3));
      txd  = 16'($urandom);
      if (dw == 8) txd[15:8] = 8'h00;
      sab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, dw - 1)) : -1;
      predict(cur, w, nb, sab, ev, ee, erx);
      run_frame(w, nb, dly, txd, sab, 1'b0, ev, ee, erx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_dp.md
# spi_slave_dp

Parametrised SPI slave front-end for the dual-port RAM wrapper. It deserialises MOSI command words into a parallel `rx_data` word plus a one-cycle `rx_valid` strobe for the RAM controller. It serialises RAM read data from `tx_data` onto MISO and tracks the read-address/read-data command pairing. Data width is generic, and the block adds command checking, an explicit wait-for-data state and a clean abort on `SS_n` deassertion.

## Interface
- `DATA_W`, default 8: RAM address/data payload width. Command word width is W = DATA_W+2, with bits [W-1:W-2] as the command and [DATA_W-1:0] as the payload.
- `clk` in 1: the single clock, which is also the SPI bit clock. All logic is on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `SS_n` in 1: slave select, active low, frame delimiter.
- `MOSI` in 1: serial in, MSB first, sampled on posedge.
- `MISO` out 1: serial out, MSB first, registered.
- `rx_data` out W: last accepted command word.
- `rx_valid` out 1: one-cycle strobe, `rx_data` valid.
- `tx_data` in DATA_W: RAM read data.
- `tx_valid` in 1: `tx_data` valid. Only sampled in `WAIT_TX`.
- `cmd_err` out 1: one-cycle strobe on an illegal read command.
- `busy` out 1: high whenever the state is not `IDLE`.

## Operation
- Command codes:
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
- Internal `rd_addr_pend` flag: reset value 1, meaning the next read command expected is a read address.
- States: `IDLE`, `CHK_CMD`, `WRITE`, `READ_ADD`, `READ_DATA`, `WAIT_TX`, `SEND`, `HOLD`.
- `IDLE`:
  - Bit counter cleared, `MISO`=0.
  - Moves to `CHK_CMD` on a posedge with `SS_n`=0.
- `CHK_CMD` captures MOSI as word bit W-1 and branches:
  - MOSI=0 goes to `WRITE`.
  - MOSI=1 with `rd_addr_pend`=1 goes to `READ_ADD`.
  - MOSI=1 with `rd_addr_pend`=0 goes to `READ_DATA`.
- `WRITE`, `READ_ADD` and `READ_DATA` each shift in the remaining W-1 bits, one per cycle. On the last bit, the full word is checked:
  - `WRITE`: either write code is accepted. `rx_data` is set to the word, `rx_valid` pulses, and the state goes to `HOLD`.
  - `READ_ADD`: code must be 10. On accept, `rx_data`/`rx_valid` as above, `rd_addr_pend` cleared, state goes to `HOLD`.
  - `READ_DATA`: code must be 11. On accept, `rx_data`/`rx_valid` as above, state goes to `WAIT_TX`.
  - On a code mismatch in either read state: `cmd_err` pulses, `rx_valid` is not asserted, `rx_data` and `rd_addr_pend` are unchanged, and the state goes to `HOLD`.
- `WAIT_TX`: on a posedge with `tx_valid`=1, `tx_data` is latched into the shift register, `MISO` is set to `tx_data[DATA_W-1]`, and the state goes to `SEND`.
- `SEND`:
  - Each posedge puts the next bit on `MISO`.
  - On the posedge after the LSB has been driven for one cycle, `MISO` returns to 0, `rd_addr_pend` is set to 1, and the state goes to `HOLD`.
- `HOLD`: MOSI is ignored. Returns to `IDLE` when `SS_n`=1.
- `SS_n`=1 on any posedge, in any state, forces `IDLE` on that edge:
  - The partial word is discarded, with no `rx_valid` and no `cmd_err`.
  - `MISO` goes to 0.
  - `rd_addr_pend` is unchanged. An aborted read-data transfer is retried with a new read-data frame.
- `tx_valid` outside `WAIT_TX` is ignored.

## Timing
- Reset values: `MISO`=0, `rx_valid`=0, `rx_data`=0, `cmd_err`=0, `busy`=0, state `IDLE`, `rd_addr_pend`=1.
- Reset is asynchronous and takes effect mid-frame immediately.
- Edge numbering within a frame:
  - Edge 0 is the first posedge with `SS_n`=0; the state becomes `CHK_CMD`.
  - Edge 1 samples bit W-1.
  - Edges 2..W sample bits W-2..0.
- `rx_data`/`rx_valid`/`cmd_err` are registered at edge W and high for exactly one cycle.
- Read data:
  - `tx_valid` may come any number of cycles after `rx_valid`; the minimum is the same cycle `rx_valid` is high.
  - The MSB appears on `MISO` after the `tx_valid` edge. Each bit holds one cycle, for DATA_W cycles total.
- Minimum frame length with `SS_n` low:
  - Write/read-address frame: W+1 edges.
  - Read-data frame: W+1 edges, plus the `tx_valid` wait, plus DATA_W+1 edges.
- `SS_n` may return high on the edge right after `HOLD` is entered. Back-to-back frames need only one `SS_n`=1 edge.

## Test plan
- DATA_W=8, write frame 00_1010_0101 → `rx_data`=0x0A5, `rx_valid` high one cycle after edge 10, `MISO` stays 0, `cmd_err`=0.
- Read pair: 10_0011_0011 → `rx_data`=0x233. Then 11_0000_0000 → `rx_valid`; `tx_valid` with 0xC6 three cycles later → `MISO` sequence 1,1,0,0,0,1,1,0, then 0. `rd_addr_pend` returns to 1.
- Read-data code while a read address is expected (11_xxxxxxxx after reset) → `cmd_err` pulse, no `rx_valid`, next read frame still treated as a read address.
- `SS_n` high after 5 bits of a write frame → no `rx_valid`, state `IDLE`. A following full frame 01_1111_0000 gives `rx_data`=0x1F0.
- `rst_n` low during `SEND` → `MISO`=0 immediately, all outputs at reset values, `rd_addr_pend`=1.
- DATA_W=16: write frame with payload 0xBEEF and code 01 → `rx_data`=0x1BEEF at edge 18. A read-data frame returns 16 `MISO` bits of `tx_data`.
